// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage pipeline: operand forwarding selects,
// load-use / PC-write stalls, wrong-path flushes and long-op Execute sequencing.
module hazard_unit #(
  parameter int LongCycles = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] MatchAE,
  input  logic [3:0] MatchBE,
  input  logic [3:0] MatchCE,
  input  logic [3:0] MatchDE,
  input  logic       RegWriteM,
  input  logic       RegWrite2M,
  input  logic       RegWriteW,
  input  logic       RegWrite2W,
  input  logic       Match_12D_E,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       LongStartE,
  output logic [2:0] ForwardAE,
  output logic [2:0] ForwardBE,
  output logic [2:0] ForwardCE,
  output logic [2:0] ForwardDE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       LongBusy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The start cycle and the DONE cycle account for two of the LongCycles.
  localparam logic [3:0] CNT_INIT = (LongCycles >= 3) ? 4'(LongCycles - 3) : 4'd0;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_long_stall;
  logic       w_ld_stall;
  logic       w_pc_pend;
  logic [3:0] w_we;

  // Nearest producer wins: Memory before Writeback, port 3 before port 0.
  function automatic logic [2:0] fwd_sel(input logic [3:0] match, input logic [3:0] we);
    logic [2:0] sel;
    if (match[0] && we[0])      sel = 3'd2;
    else if (match[1] && we[1]) sel = 3'd3;
    else if (match[2] && we[2]) sel = 3'd1;
    else if (match[3] && we[3]) sel = 3'd4;
    else                        sel = 3'd0;
    return sel;
  endfunction

  assign w_we = {RegWrite2W, RegWriteW, RegWrite2M, RegWriteM};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_long_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (LongStartE) begin
          w_long_stall = 1'b1;
          if (LongCycles == 2) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_BUSY: begin
        w_long_stall = 1'b1;
        if (r_cnt == 4'd0) w_state_nxt = S_DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      // LongStartE here still belongs to the op that is leaving Execute.
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_ld_stall = Match_12D_E & MemtoRegE;
  assign w_pc_pend  = PCSrcD | PCSrcE | PCSrcM;

  // Every control output is forced quiet while reset is held low.
  assign ForwardAE = reset ? fwd_sel(MatchAE, w_we) : 3'd0;
  assign ForwardBE = reset ? fwd_sel(MatchBE, w_we) : 3'd0;
  assign ForwardCE = reset ? fwd_sel(MatchCE, w_we) : 3'd0;
  assign ForwardDE = reset ? fwd_sel(MatchDE, w_we) : 3'd0;

  assign StallF   = reset & (w_ld_stall | w_pc_pend | w_long_stall);
  assign StallD   = reset & (w_ld_stall | w_long_stall);
  assign StallE   = reset & w_long_stall;
  assign FlushD   = reset & (w_pc_pend | PCSrcW | BranchTakenE);
  assign FlushE   = reset & (w_ld_stall | BranchTakenE) & ~w_long_stall;
  assign FlushM   = reset & w_long_stall;
  assign LongBusy = (r_state != S_IDLE);

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed steps then random traffic against an
// occupancy-based reference model, for LongCycles=4 and LongCycles=2.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] MatchAE, MatchBE, MatchCE, MatchDE;
  logic       RegWriteM, RegWrite2M, RegWriteW, RegWrite2W;
  logic       Match_12D_E, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic       BranchTakenE, LongStartE;

  logic [2:0] a_fa, a_fb, a_fc, a_fd;
  logic       a_sf, a_sd, a_se, a_fld, a_fle, a_flm, a_busy;
  logic [2:0] b_fa, b_fb, b_fc, b_fd;
  logic       b_sf, b_sd, b_se, b_fld, b_fle, b_flm, b_busy;

  int    n_pass  = 0;
  int    n_fail  = 0;
  int    n_total = 0;
  int    pos [2];
  int    lc  [2];
  string step;

  always #5 clk = ~clk;

  hazard_unit #(.LongCycles(4)) u_lc4 (
    .clk(clk), .reset(reset),
    .MatchAE(MatchAE), .MatchBE(MatchBE), .MatchCE(MatchCE), .MatchDE(MatchDE),
    .RegWriteM(RegWriteM), .RegWrite2M(RegWrite2M), .RegWriteW(RegWriteW), .RegWrite2W(RegWrite2W),
    .Match_12D_E(Match_12D_E), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .LongStartE(LongStartE),
    .ForwardAE(a_fa), .ForwardBE(a_fb), .ForwardCE(a_fc), .ForwardDE(a_fd),
    .StallF(a_sf), .StallD(a_sd), .StallE(a_se),
    .FlushD(a_fld), .FlushE(a_fle), .FlushM(a_flm), .LongBusy(a_busy)
  );

  hazard_unit #(.LongCycles(2)) u_lc2 (
    .clk(clk), .reset(reset),
    .MatchAE(MatchAE), .MatchBE(MatchBE), .MatchCE(MatchCE), .MatchDE(MatchDE),
    .RegWriteM(RegWriteM), .RegWrite2M(RegWrite2M), .RegWriteW(RegWriteW), .RegWrite2W(RegWrite2W),
    .Match_12D_E(Match_12D_E), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .LongStartE(LongStartE),
    .ForwardAE(b_fa), .ForwardBE(b_fb), .ForwardCE(b_fc), .ForwardDE(b_fd),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se),
    .FlushD(b_fld), .FlushE(b_fle), .FlushM(b_flm), .LongBusy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, expv);
    end
  endtask

  // Producers in priority order: M port3, M port0, W port3, W port0.
  function automatic logic [2:0] ref_fwd(input logic [3:0] m, input logic [3:0] we);
    int code [4];
    code = '{2, 3, 1, 4};
    if (!reset) return 3'd0;
    for (int i = 0; i < 4; i++)
      if (m[i] && we[i]) return 3'(code[i]);
    return 3'd0;
  endfunction

  // pos = cycles the current long op has already spent in Execute (-1: none).
  function automatic logic [6:0] ref_ctrl(input int k);
    int p;
    bit ls, busy, ld, pc;
    p    = (pos[k] < 0 && LongStartE) ? 0 : pos[k];
    ls   = (p >= 0) && (p <= lc[k] - 2);
    busy = (pos[k] >= 1);
    ld   = Match_12D_E && MemtoRegE;
    pc   = PCSrcD || PCSrcE || PCSrcM;
    if (!reset) return 7'd0;
    return {ld | pc | ls, ld | ls, ls, pc | PCSrcW | BranchTakenE,
            (ld | BranchTakenE) & ~ls, ls, busy};
  endfunction

  task automatic check_all();
    logic [3:0] we;
    if (!reset) begin
      pos[0] = -1;
      pos[1] = -1;
    end
    we = {RegWrite2W, RegWriteW, RegWrite2M, RegWriteM};
    chk("lc4_FwdA", 32'(a_fa), 32'(ref_fwd(MatchAE, we)));
    chk("lc4_FwdB", 32'(a_fb), 32'(ref_fwd(MatchBE, we)));
    chk("lc4_FwdC", 32'(a_fc), 32'(ref_fwd(MatchCE, we)));
    chk("lc4_FwdD", 32'(a_fd), 32'(ref_fwd(MatchDE, we)));
    chk("lc2_Fwd", 32'({b_fa, b_fb, b_fc, b_fd}),
        32'({ref_fwd(MatchAE, we), ref_fwd(MatchBE, we), ref_fwd(MatchCE, we), ref_fwd(MatchDE, we)}));
    chk("lc4_StallF_D_E", 32'({a_sf, a_sd, a_se}), 32'(ref_ctrl(0) >> 4));
    chk("lc4_FlushD_E_M", 32'({a_fld, a_fle, a_flm}), 32'((ref_ctrl(0) >> 1) & 7'h7));
    chk("lc4_LongBusy", 32'(a_busy), 32'(ref_ctrl(0) & 7'h1));
    chk("lc2_ctrl", 32'({b_sf, b_sd, b_se, b_fld, b_fle, b_flm, b_busy}), 32'(ref_ctrl(1)));
  endtask

  task automatic cyc();
    #1;
    check_all();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!reset) pos[k] = -1;
      else begin
        if (pos[k] < 0 && LongStartE) pos[k] = 0;
        if (pos[k] >= 0) begin
          pos[k]++;
          if (pos[k] >= lc[k]) pos[k] = -1;
        end
      end
    end
    #1;
  endtask

  task automatic clr();
    {MatchAE, MatchBE, MatchCE, MatchDE} = '0;
    {RegWriteM, RegWrite2M, RegWriteW, RegWrite2W} = '0;
    {Match_12D_E, MemtoRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW} = '0;
    {BranchTakenE, LongStartE} = '0;
  endtask

  initial begin
    pos = '{-1, -1};
    lc  = '{4, 2};
    reset = 1'b1;
    clr();
    #2;

    step = "reset";
    reset = 1'b0;
    MatchAE = 4'hF; MatchDE = 4'hF;
    {RegWriteM, RegWrite2M, RegWriteW, RegWrite2W} = 4'hF;
    LongStartE = 1'b1; BranchTakenE = 1'b1; PCSrcD = 1'b1; Match_12D_E = 1'b1; MemtoRegE = 1'b1;
    cyc(); cyc();
    clr();
    reset = 1'b1;
    step = "idle";
    cyc();

    step = "fwd";
    for (int op = 0; op < 4; op++) begin
      for (int drop = 0; drop <= 4; drop++) begin
        clr();
        case (op)
          0: MatchAE = 4'hF;
          1: MatchBE = 4'hF;
          2: MatchCE = 4'hF;
          default: MatchDE = 4'hF;
        endcase
        {RegWrite2W, RegWriteW, RegWrite2M, RegWriteM} = 4'(4'hF << drop);
        cyc();
      end
    end
    clr();

    step = "loaduse";
    Match_12D_E = 1'b1; MemtoRegE = 1'b1;
    cyc();
    clr();
    cyc();

    step = "branch";
    BranchTakenE = 1'b1;
    cyc();
    clr();
    step = "pcwrite";
    PCSrcD = 1'b1; cyc();
    PCSrcD = 1'b0; PCSrcE = 1'b1; cyc();
    PCSrcE = 1'b0; PCSrcM = 1'b1; cyc();
    PCSrcM = 1'b0; PCSrcW = 1'b1; cyc();
    clr(); cyc();

    step = "longop";
    LongStartE = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    LongStartE = 1'b0;
    cyc(); cyc();

    step = "long_ld";
    LongStartE = 1'b1;
    cyc();
    Match_12D_E = 1'b1; MemtoRegE = 1'b1;
    cyc(); cyc(); cyc();
    LongStartE = 1'b0;
    cyc();
    clr(); cyc();

    step = "reset_mid";
    LongStartE = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    LongStartE = 1'b0;
    cyc(); cyc();

    step = "random";
    for (int i = 0; i < 400; i++) begin
      MatchAE = 4'($urandom); MatchBE = 4'($urandom);
      MatchCE = 4'($urandom); MatchDE = 4'($urandom);
      {RegWriteM, RegWrite2M, RegWriteW, RegWrite2W} = 4'($urandom);
      Match_12D_E  = ($urandom_range(0, 3) == 0);
      MemtoRegE    = ($urandom_range(0, 1) == 0);
      {PCSrcD, PCSrcE, PCSrcM, PCSrcW} = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      BranchTakenE = ($urandom_range(0, 7) == 0);
      LongStartE   = ($urandom_range(0, 2) == 0);
      reset        = ($urandom_range(0, 24) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage datapath. It does four jobs:
- turns the datapath's register-address match signals into the four 3-bit forwarding selects;
- detects load-use hazards and PC-write hazards;
- flushes wrong-path instructions on taken branches;
- sequences multi-cycle long operations (long multiply, saturating/long ALU ops) by holding Execute for a fixed number of cycles.

It sits beside the datapath and drives its ForwardXE, StallF/StallD, FlushD/FlushE inputs. It also drives two new controls: StallE on the Decode-to-Execute register enable, and FlushM on the Execute-to-Memory register clear.

## Interface
Parameters:
- LongCycles, 4, number of cycles a long op occupies Execute. Legal range is 2..16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low. reset=0 clears all state immediately.
- MatchAE, MatchBE, MatchCE, MatchDE  in  4 each  source-operand match vectors for operands A/B/C/D in Execute.
  - bit0: equals WA3M
  - bit1: equals WA0M
  - bit2: equals WA3W
  - bit3: equals WA0W
- RegWriteM, RegWrite2M, RegWriteW, RegWrite2W  in  1 each  write enables of port 3 and port 0 in Memory and Writeback.
- Match_12D_E  in  1  a Decode source register equals WA3E.
- MemtoRegE  in  1  the instruction in Execute is a load.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  the instruction in that stage writes R15.
- BranchTakenE  in  1  a branch resolved taken in Execute.
- LongStartE  in  1  the instruction in Execute is a long op.
- ForwardAE, ForwardBE, ForwardCE, ForwardDE  out  3 each  forwarding select.
  - 0: register file
  - 1: ResultW
  - 2: ALUOutM
  - 3: ALUOut2M
  - 4: Result2W
- StallF, StallD, StallE  out  1  hold the PC / Fetch-to-Decode / Decode-to-Execute register (1 = hold). The top level drives each datapath enable with the inverse.
- FlushD, FlushE, FlushM  out  1  synchronous clear of the corresponding pipeline register.
- LongBusy  out  1  a long op is being sequenced, i.e. the FSM is not in IDLE.

## Operation
- **Forwarding.** Each operand X is handled independently. Priority, highest first:
  - MatchXE[0]&RegWriteM gives 2;
  - else MatchXE[1]&RegWrite2M gives 3;
  - else MatchXE[2]&RegWriteW gives 1;
  - else MatchXE[3]&RegWrite2W gives 4;
  - else 0.
  - This logic is purely combinational. Codes 5..7 are never produced.
- **Load-use.** ldStall = Match_12D_E & MemtoRegE.
- **PC-write pending.** pcPend = PCSrcD|PCSrcE|PCSrcM.
- **Long-op FSM states:** IDLE, BUSY, DONE. Down-counter cnt is 4 bits wide.
  - IDLE & LongStartE: longStall=1 this cycle. If LongCycles==2, next state is DONE. Otherwise next state is BUSY with cnt=LongCycles-3.
  - BUSY: longStall=1. If cnt==0, next state is DONE; else cnt decrements.
  - DONE: longStall=0, so the op leaves Execute at this edge. LongStartE is ignored because it still refers to the same op. Next state is IDLE.
  - Result: total Execute occupancy is exactly LongCycles cycles, of which LongCycles-1 are stalled.
- **Output equations:**
  - StallF = ldStall | pcPend | longStall
  - StallD = ldStall | longStall
  - StallE = longStall
  - FlushD = pcPend | PCSrcW | BranchTakenE
  - FlushE = (ldStall | BranchTakenE) & ~longStall
  - FlushM = longStall
- **Precedence rules:**
  - Flush overrides stall on the same register. FlushD kills a wrong-path instruction even while D is stalled.
  - During longStall, FlushE is suppressed so the held long op is not destroyed. The load-use bubble is re-evaluated once the stall releases.
  - BranchTakenE and LongStartE are mutually exclusive by decode. If both are seen, the branch is honoured in FlushD and the FSM still starts.
- **Reset:**
  - reset=0 forces the FSM to IDLE, cnt to 0, and LongBusy to 0.
  - While reset=0, all stall and flush outputs are 0 and all Forward selects are 0.
  - A reset in the middle of BUSY abandons the op. After release, a still-high LongStartE starts a fresh sequence.

## Timing
- Forwarding, hazard, and flush outputs are combinational from the inputs in the same cycle, plus FSM state for the long-op terms.
- longStall is asserted in the same cycle that LongStartE first rises in IDLE, so there is zero-cycle latency to the stall.
- LongBusy is registered. It goes high the cycle after the start and falls the cycle after DONE.
- Only the FSM state and cnt are registered.

## Test plan
- **Forward priority.** MatchAE=4'b1111 with RegWriteM=RegWrite2M=RegWriteW=RegWrite2W=1 gives ForwardAE=2. Dropping RegWriteM gives 3, dropping RegWrite2M next gives 1, then 4, and all four writes low gives 0. Repeat for operands B, C, D.
- **Load-use.** Match_12D_E=1 and MemtoRegE=1 for one cycle gives StallF=StallD=FlushE=1 for exactly that cycle, with StallE=0.
- **Branch.** BranchTakenE=1 gives FlushD=FlushE=1 and StallF=0. With PCSrcE=1 instead, StallF=1 and FlushD=1 while pcPend holds, and FlushD stays 1 through PCSrcW.
- **Long op, LongCycles=4.** Hold LongStartE high.
  - StallF=StallD=StallE=FlushM=1 for exactly 3 cycles, then 0 in the DONE cycle.
  - LongBusy is high for 3 cycles.
  - No retrigger occurs after DONE unless LongStartE is presented again from IDLE.
- **Long op with load-use.** Assert ldStall during BUSY: FlushE stays 0 and StallD=1. After DONE, ldStall alone gives FlushE=1.
- **Reset mid-op.** Pull reset=0 in the second BUSY cycle: all outputs are 0 asynchronously and the FSM returns to IDLE. After release with LongStartE=1, a full new 3-cycle stall occurs. Repeat with LongCycles=2 and confirm a 1-cycle stall.
